// File: rtl/mult_seq_ctrl.sv
// Control FSM for an NBits x NBits sequential signed shift-add multiplier.
// Sequences operand load, NBits add/shift steps and sign correction, then flags the product valid.
module mult_seq_ctrl #(
  parameter int NBits = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic abort,
  input  logic sign_a,
  input  logic sign_b,
  input  logic mult_lsb,
  output logic load,
  output logic add,
  output logic shift,
  output logic mux_sel,
  output logic mux_enable,
  output logic busy,
  output logic done
);

  localparam int CW = $clog2(NBits) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(NBits - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_CALC = 3'd2;
  localparam logic [2:0] S_SIGN = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]    state;
  logic [2:0]    state_next;
  logic [CW-1:0] count;
  logic          sign_q;
  logic          result_valid;
  logic          last_step;

  assign last_step = (count == LAST_STEP);

  // Abort overrides every transition; unused encodings fall back to IDLE.
  always_comb begin
    state_next = S_IDLE;
    if (!abort) begin
      case (state)
        S_IDLE:  state_next = start ? S_LOAD : S_IDLE;
        S_LOAD:  state_next = S_CALC;
        S_CALC:  state_next = last_step ? S_SIGN : S_CALC;
        S_SIGN:  state_next = S_DONE;
        S_DONE:  state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // result_valid is cleared on entry to LOAD and set on entry to DONE, so the
  // product enable is low throughout a run and already high in the done cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      count        <= '0;
      sign_q       <= 1'b0;
      result_valid <= 1'b0;
      mux_sel      <= 1'b0;
    end else begin
      state <= state_next;
      if (abort) begin
        count        <= '0;
        result_valid <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) result_valid <= 1'b0;
          end
          S_LOAD: begin
            sign_q       <= sign_a ^ sign_b;
            count        <= '0;
            result_valid <= 1'b0;
          end
          S_CALC: begin
            count <= count + CW'(1);
            if (last_step) mux_sel <= sign_q;
          end
          S_SIGN: begin
            result_valid <= 1'b1;
          end
          default: begin
          end
        endcase
      end
    end
  end

  always_comb begin
    load  = 1'b0;
    add   = 1'b0;
    shift = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state)
      S_LOAD: begin
        load = 1'b1;
        busy = 1'b1;
      end
      S_CALC: begin
        shift = 1'b1;
        add   = mult_lsb;
        busy  = 1'b1;
      end
      S_SIGN: begin
        busy = 1'b1;
      end
      S_DONE: begin
        busy = 1'b1;
        done = ~abort;
      end
      default: begin
      end
    endcase
  end

  assign mux_enable = result_valid;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl (NBits=8): done pulses are matched against a
// queue of expected completion cycles and sign selections.
module tb_mult_seq_ctrl;

  localparam int NBITS = 8;

  logic clk = 1'b0;
  logic reset, start, abort, sign_a, sign_b, mult_lsb;
  logic load, add, shift, mux_sel, mux_enable, busy, done;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int last_done = -1;
  int prev_done = -1;

  typedef struct {
    int   cyc;
    logic sel;
  } exp_t;

  exp_t scoreboard[$];
  exp_t mon_e;

  mult_seq_ctrl #(.NBits(NBITS)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .sign_a(sign_a), .sign_b(sign_b), .mult_lsb(mult_lsb),
    .load(load), .add(add), .shift(shift), .mux_sel(mux_sel),
    .mux_enable(mux_enable), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every done pulse must match the oldest expectation; an overdue one is a miss.
  always @(negedge clk) begin
    if (!reset) begin
      if (done) begin
        if (scoreboard.size() == 0) begin
          check("unexpected_done", done, 0);
        end else begin
          mon_e = scoreboard.pop_front();
          check("done_cycle", cyc, mon_e.cyc);
          check("done_mux_sel", mux_sel, mon_e.sel);
          check("done_mux_enable", mux_enable, 1);
          check("done_strobes", {load, add, shift}, 0);
          prev_done = last_done;
          last_done = cyc;
        end
      end else if (scoreboard.size() > 0 && cyc > scoreboard[0].cyc) begin
        check("done_missing", done, 1);
        void'(scoreboard.pop_front());
      end
    end
  end

  // Drives one multiply from IDLE and returns at the IDLE cycle after done.
  task automatic run_mult(input logic sa, input logic sb_in, input logic [7:0] bits,
                          input logic exp_sel, input bit glitch);
    exp_t x;
    start  = 1'b1;
    sign_a = sa;
    sign_b = sb_in;
    x.cyc = cyc + NBITS + 3;
    x.sel = exp_sel;
    scoreboard.push_back(x);
    @(negedge clk);
    check("idle_busy", busy, 0);
    tick();
    start = 1'b0;
    @(negedge clk);
    check("load_strobes", {load, add, shift}, 3'b100);
    check("load_mux_enable", mux_enable, 0);
    check("load_busy", busy, 1);
    tick();
    for (int i = 0; i < NBITS; i++) begin
      mult_lsb = bits[i];
      if (glitch) start = (i == 3);
      @(negedge clk);
      check("calc_strobes", {load, add, shift}, {1'b0, bits[i], 1'b1});
      tick();
    end
    mult_lsb = 1'b0;
    start    = 1'b0;
    @(negedge clk);
    check("sign_strobes", {load, add, shift}, 0);
    check("sign_mux_sel", mux_sel, exp_sel);
    tick();
    tick();
  endtask

  task automatic idle_check(input logic exp_en, input logic exp_sel);
    @(negedge clk);
    check("idle_busy_after", busy, 0);
    check("idle_mux_enable", mux_enable, exp_en);
    check("idle_mux_sel", mux_sel, exp_sel);
    tick();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    sign_a = 1'b0; sign_b = 1'b0; mult_lsb = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    check("reset_outputs", {load, add, shift, mux_sel, mux_enable, busy, done}, 0);
    reset = 1'b0;
    tick();

    $display("[TB] 3 x 5");
    run_mult(1'b0, 1'b0, 8'd5, 1'b0, 1'b0);
    idle_check(1'b1, 1'b0);

    $display("[TB] -3 x 5 and -3 x -5");
    run_mult(1'b1, 1'b0, 8'd5, 1'b1, 1'b0);
    idle_check(1'b1, 1'b1);
    run_mult(1'b1, 1'b1, 8'd5, 1'b0, 1'b0);
    idle_check(1'b1, 1'b0);

    $display("[TB] start during CALC, then back-to-back");
    run_mult(1'b0, 1'b0, 8'b1010_0110, 1'b0, 1'b1);
    run_mult(1'b1, 1'b0, 8'b0110_0011, 1'b1, 1'b0);
    check("b2b_done_gap", last_done - prev_done, NBITS + 4);
    idle_check(1'b1, 1'b1);

    $display("[TB] abort in CALC with start");
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    repeat (4) tick();
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check("abort_calc_done", done, 0);
    tick();
    abort = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("abort_calc_idle", {busy, mux_enable, load}, 0);
    tick();
    repeat (14) tick();

    $display("[TB] abort in DONE cycle");
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (NBITS + 2) tick();
    abort = 1'b1;
    @(negedge clk);
    check("abort_done_pulse", done, 0);
    check("abort_done_busy", busy, 1);
    tick();
    abort = 1'b0;
    @(negedge clk);
    check("abort_done_after", {busy, mux_enable}, 0);
    tick();

    $display("[TB] start held high");
    begin
      exp_t x;
      int s;
      s = cyc;
      start  = 1'b1;
      sign_a = 1'b1;
      sign_b = 1'b0;
      for (int k = 0; k < 3; k++) begin
        x.cyc = s + k * (NBITS + 4) + NBITS + 3;
        x.sel = 1'b1;
        scoreboard.push_back(x);
      end
      for (int c = 0; c < 3 * (NBITS + 4); c++) begin
        if (c == 2 * (NBITS + 4) + 1) start = 1'b0;
        @(negedge clk);
        if (c % (NBITS + 4) == 1) check("held_load", {load, mux_enable}, 2'b10);
        if (c % (NBITS + 4) == 0 && c > 0) check("held_idle_enable", mux_enable, 1);
        tick();
      end
    end
    idle_check(1'b1, 1'b1);

    $display("[TB] reset mid-CALC");
    start  = 1'b1;
    sign_a = 1'b1;
    sign_b = 1'b0;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("reset_mid_calc", {load, add, shift, mux_sel, mux_enable, busy, done}, 0);
    tick();
    reset = 1'b0;
    repeat (14) tick();
    @(negedge clk);
    check("post_reset_idle", {busy, mux_enable, mux_sel}, 0);
    tick();

    repeat (5) tick();
    check("scoreboard_empty", scoreboard.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
